kyber_ntt_core: RTL
===================

// Module: kyber_ntt_core
// PURPOSE
// - Forward Kyber NTT engine; direct consumer of the 128x12 zeta ROM (dist_mem_gen_5): drives its address/enable, consumes its dout.
// - In-place Cooley-Tukey NTT on a 256x12 coefficient RAM, q=3329, 7 layers (len 128..2), 896 butterflies.
// - Sits between polynomial load/unload logic and the Kyber arithmetic datapath; launched by start, reports done.
// PARAMETERS
// - Q       3329  modulus
// - BARR_M  5039  Barrett constant floor(2^24/Q)
// - PIPE    4     fixed read-to-write latency, cycles
// PORTS
// - clk        in   1   system clock
// - reset      in   1   synchronous, active-high reset
// - start      in   1   one-cycle launch pulse; ignored while busy
// - busy       out  1   high from cycle after accepted start until done
// - done       out  1   one-cycle pulse, transform complete
// - zeta_ad    out  7   zeta ROM address
// - zeta_ce    out  1   zeta ROM clock enable
// - zeta_oce   out  1   zeta ROM output enable (tied 1 while busy)
// - zeta_dout  in   12  zeta ROM data, valid 1 cycle after zeta_ad/ce
// - rd_addr_a  out  8   coefficient RAM read addr, element j
// - rd_addr_b  out  8   coefficient RAM read addr, element j+len
// - rd_data_a  in   12  read data a, 1-cycle latency
// - rd_data_b  in   12  read data b, 1-cycle latency
// - wr_en      out  1   write strobe (both ports)
// - wr_addr_a  out  8   write address a
// - wr_addr_b  out  8   write address b
// - wr_data_a  out  12  a + zeta*b mod Q
// - wr_data_b  out  12  a - zeta*b mod Q
// BEHAVIOUR
// - Reset values: busy=0, done=0, wr_en=0, zeta_ce=0, zeta_oce=0, all addresses/data 0; FSM->IDLE.
// - FSM: IDLE -(start)-> ISSUE -(128 butterflies issued)-> DRAIN -(PIPE cycles)-> ISSUE (next layer) or DONE after layer 6; DONE -> IDLE (done=1 for 1 cycle).
// - ISSUE: one butterfly/cycle. Layer l=0..6, len=128>>l, block b=0..2^l-1, j=2b*len+i, i<len.
// - Issue: rd_addr_a=j, rd_addr_b=j+len, zeta_ad=(1<<l)+b (k=1..127), zeta_ce=1.
// - Stage1: rd_data_a/b and zeta_dout valid together, registered.
// - Stage2: p = zeta*b, 24-bit product, registered.
// - Stage3: t = p - Q*((p*BARR_M)>>24), then conditional subtracts until t<Q (max 2); registered.
// - Stage4: wr_data_a=(a+t)>=Q ? a+t-Q : a+t; wr_data_b=(a>=t) ? a-t : a-t+Q; wr_en=1, addresses delayed copies of issue addresses.
// - Inputs assumed <Q; outputs always in [0,Q-1].
// - DRAIN between layers: no issue until last write of layer retired; no RAW hazard.
// - Timing: start sampled in cycle 0 -> layer l issues in cycles 1+132l..128+132l; done high in cycle 925.
// - wr_en high exactly 896 cycles per transform.
// - start while busy or in DONE: ignored, no restart.
// - reset mid-transform: next cycle busy=0, wr_en=0, pipeline flushed; no further writes; RAM left partially transformed.
// - zeta_ce low outside ISSUE; ROM address held at last value.
// CONFIGURATION
// - KYBER_NTT_CYC_CNT_EN defined: extra output cyc_cnt[15:0]; cleared on accepted start, +1 each busy cycle, frozen at done (value 925), cleared by reset.
// - Undefined: no cyc_cnt port, no counter logic; all other behaviour identical.
// TESTING
// - All-zero RAM, start -> 896 writes of 0, done exactly 925 cycles after start.
// - coeff[0]=1, rest 0 -> all 256 outputs = 1.
// - coeff[128]=1, rest 0 -> after layer 0 writes: addr0=1729, addr128=1600; final RAM matches golden model.
// - All coeffs=3328 (Barrett worst case) and 20 random vectors -> bit-exact vs C reference NTT.
// - zeta_ad trace: 1 x128, then 2 x64, 3 x64, ..., 64..127 x2 each, no out-of-order addresses.
// - start pulsed at cycle 300 -> ignored, single done; reset at cycle 500 -> busy=0 and wr_en=0 next cycle, new start runs full 925 cycles.

Source files
------------

// File: rtl/kyber_ntt_core.sv
// Forward Kyber NTT engine: in-place Cooley-Tukey over a 256x12 RAM with a 4-cycle butterfly pipeline.
// Optional KYBER_NTT_CYC_CNT_EN adds a cyc_cnt[15:0] busy-cycle counter output.
module kyber_ntt_core #(
    parameter int Q      = 3329,
    parameter int BARR_M = 5039
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [6:0]  zeta_ad,
    output logic        zeta_ce,
    output logic        zeta_oce,
    input  logic [11:0] zeta_dout,
    output logic [7:0]  rd_addr_a,
    output logic [7:0]  rd_addr_b,
    input  logic [11:0] rd_data_a,
    input  logic [11:0] rd_data_b,
    output logic        wr_en,
    output logic [7:0]  wr_addr_a,
    output logic [7:0]  wr_addr_b,
    output logic [11:0] wr_data_a,
    output logic [11:0] wr_data_b
`ifdef KYBER_NTT_CYC_CNT_EN
   ,output logic [15:0] cyc_cnt
`endif
);
    localparam int          PIPE     = 4;
    localparam int          STAGES   = PIPE - 1;
    localparam logic [1:0]  DRN_LAST = 2'(PIPE - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
    state_t state, state_nxt;

    logic [2:0] layer, nxt_layer;
    logic [6:0] bf, nxt_bf;
    logic [1:0] drn_cnt;
    logic       load_iss;
    logic [7:0] len_n, j_n;
    logic [6:0] k_n;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // load_iss marks that the next cycle issues butterfly (nxt_layer, nxt_bf)
    always_comb begin
        state_nxt = state;
        load_iss  = 1'b0;
        nxt_layer = layer;
        nxt_bf    = bf;
        case (state)
            IDLE: if (start) begin
                state_nxt = ISSUE;
                load_iss  = 1'b1;
                nxt_layer = 3'd0;
                nxt_bf    = 7'd0;
            end
            ISSUE: if (bf == 7'd127) state_nxt = DRAIN;
                   else begin
                       load_iss = 1'b1;
                       nxt_bf   = bf + 7'd1;
                   end
            DRAIN: if (drn_cnt == DRN_LAST) begin
                if (layer == 3'd6) state_nxt = FIN;
                else begin
                    state_nxt = ISSUE;
                    load_iss  = 1'b1;
                    nxt_layer = layer + 3'd1;
                    nxt_bf    = 7'd0;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == FIN);
        zeta_ce  = (state == ISSUE);
        zeta_oce = busy;
    end

    // j = 2*b*len + i equals bf + b*len, and b*len is just bf with the low log2(len) bits cleared
    always_comb begin
        len_n = 8'd128 >> nxt_layer;
        j_n   = {1'b0, nxt_bf} + ({1'b0, nxt_bf} & ~(len_n - 8'd1));
        k_n   = (7'd1 << nxt_layer) + (nxt_bf >> (3'd7 - nxt_layer));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            layer     <= 3'd0;
            bf        <= 7'd0;
            drn_cnt   <= 2'd0;
            rd_addr_a <= 8'd0;
            rd_addr_b <= 8'd0;
            zeta_ad   <= 7'd0;
        end else begin
            layer   <= nxt_layer;
            bf      <= nxt_bf;
            drn_cnt <= (state == DRAIN) ? drn_cnt + 2'd1 : 2'd0;
            if (load_iss) begin
                rd_addr_a <= j_n;
                rd_addr_b <= j_n + len_n;
                zeta_ad   <= k_n;
            end
        end
    end

    // vld_pipe[0] = RAM/ROM data returning, vld_pipe[STAGES] = write cycle
    logic [STAGES:0]       vld_pipe;
    logic [STAGES:0][7:0]  wa_pipe, wb_pipe;
    logic [11:0]           a1, b1, z1, a2, a3, t3;
    logic [23:0]           p2;
    logic [11:0]           qh, t_red;
    logic [13:0]           t0, t1, t2;
    logic [12:0]           sum;

    always_comb begin
        qh    = 12'((37'(p2) * 37'(BARR_M)) >> 24);
        t0    = 14'(p2 - 24'(qh) * 24'(Q));
        t1    = (t0 >= 14'(Q)) ? t0 - 14'(Q) : t0;
        t2    = (t1 >= 14'(Q)) ? t1 - 14'(Q) : t1;
        t_red = 12'(t2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            wa_pipe  <= '0;
            wb_pipe  <= '0;
            a1 <= '0; b1 <= '0; z1 <= '0;
            a2 <= '0; p2 <= '0;
            a3 <= '0; t3 <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], (state == ISSUE)};
            wa_pipe  <= {wa_pipe[STAGES-1:0], rd_addr_a};
            wb_pipe  <= {wb_pipe[STAGES-1:0], rd_addr_b};
            a1 <= rd_data_a;
            b1 <= rd_data_b;
            z1 <= zeta_dout;
            a2 <= a1;
            p2 <= 24'(z1) * 24'(b1);
            a3 <= a2;
            t3 <= t_red;
        end
    end

    assign sum       = 13'(a3) + 13'(t3);
    assign wr_en     = vld_pipe[STAGES];
    assign wr_addr_a = wa_pipe[STAGES];
    assign wr_addr_b = wb_pipe[STAGES];
    assign wr_data_a = (sum >= 13'(Q)) ? 12'(sum - 13'(Q)) : sum[11:0];
    assign wr_data_b = (a3 >= t3) ? a3 - t3 : a3 - t3 + 12'(Q);

`ifdef KYBER_NTT_CYC_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)                       cyc_cnt <= 16'd0;
        else if (state == IDLE && start) cyc_cnt <= 16'd0;
        else if (busy)                   cyc_cnt <= cyc_cnt + 16'd1;
    end
`endif
endmodule
